router_fsm_np: RTL

- Parametrised next-generation router control FSM: one input packet stream steered to NUM_PORTS destination FIFOs, replacing the fixed 3-port controller.
- Decodes the header address, sequences header, payload and parity loads, and stalls on a full destination FIFO.
- Adds invalid-address packet drop and per-port soft reset keyed to the latched destination.
- Sits between the input register block (data_in, parity) and the FIFO write-select logic.

---
 rtl/router_fsm_np.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/router_fsm_np.sv
// Router control FSM: steers one packet stream to NUM_PORTS destination FIFOs.
// Optional WAIT_TILL_EMPTY timeout drop is built when ROUTER_WAIT_TIMEOUT_EN is defined.
module router_fsm_np #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 30
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic [ADDR_W-1:0]    dest_addr,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 full_state,
  output logic                 laf_state,
  output logic                 rst_int_reg,
  output logic                 drop_state,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic                 wait_timeout
);

  localparam logic [3:0] DECODE_ADDRESS     = 4'd0;
  localparam logic [3:0] LOAD_FIRST_DATA    = 4'd1;
  localparam logic [3:0] LOAD_DATA          = 4'd2;
  localparam logic [3:0] FIFO_FULL_STATE    = 4'd3;
  localparam logic [3:0] LOAD_AFTER_FULL    = 4'd4;
  localparam logic [3:0] LOAD_PARITY        = 4'd5;
  localparam logic [3:0] CHECK_PARITY_ERROR = 4'd6;
  localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd7;
  localparam logic [3:0] DROP_PACKET        = 4'd8;

  localparam int              ADDR_SPAN = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] NP_EXT    = (ADDR_W + 1)'(NUM_PORTS);

  logic [3:0]           state_q, state_d;
  logic [ADDR_W-1:0]    dest_addr_q, dest_addr_d;
  logic [ADDR_SPAN-1:0] empty_pad, soft_pad;
  logic                 addr_invalid, soft_hit, timeout_fire;

  // Widen per-port flags to the full address space so out-of-range addresses read as 0.
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_SPAN; gi++) begin : g_pad
      if (gi < NUM_PORTS) begin : g_port
        assign empty_pad[gi] = fifo_empty[gi];
        assign soft_pad[gi]  = soft_reset[gi];
      end else begin : g_none
        assign empty_pad[gi] = 1'b0;
        assign soft_pad[gi]  = 1'b0;
      end
    end
  endgenerate

  assign addr_invalid = ({1'b0, data_in} >= NP_EXT);
  assign soft_hit     = soft_pad[dest_addr_q] && (state_q != DECODE_ADDRESS);

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             wait_timeout_q, wait_timeout_d;

  assign timeout_fire   = (state_q == WAIT_TILL_EMPTY) && (wait_cnt_q == CNT_LAST)
                          && !empty_pad[dest_addr_q];
  assign wait_cnt_d     = (state_q == WAIT_TILL_EMPTY) ? wait_cnt_q + 1'b1 : '0;
  assign wait_timeout_d = timeout_fire && !soft_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q     <= '0;
      wait_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      wait_timeout_q <= wait_timeout_d;
    end
  end

  assign wait_timeout = wait_timeout_q;
`else
  assign timeout_fire = 1'b0;
  assign wait_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (addr_invalid)             state_d = DROP_PACKET;
          else if (empty_pad[data_in])  state_d = LOAD_FIRST_DATA;
          else                          state_d = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        // An emptying FIFO beats a simultaneous timeout.
        if (empty_pad[dest_addr_q]) state_d = LOAD_FIRST_DATA;
        else if (timeout_fire)      state_d = DROP_PACKET;
      end
      DROP_PACKET: if (!pkt_valid) state_d = DECODE_ADDRESS;
      default:     state_d = DECODE_ADDRESS;
    endcase
    if (soft_hit) state_d = DECODE_ADDRESS;
  end

  always_comb begin
    dest_addr_d = dest_addr_q;
    if (state_q == DECODE_ADDRESS && pkt_valid) dest_addr_d = data_in;
    if (soft_hit)                               dest_addr_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= DECODE_ADDRESS;
      dest_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      dest_addr_q <= dest_addr_d;
    end
  end

  assign dest_addr     = dest_addr_q;
  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign drop_state    = (state_q == DROP_PACKET);
  assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL)
                         || (state_q == LOAD_PARITY);
  assign busy          = (state_q == LOAD_FIRST_DATA) || (state_q == FIFO_FULL_STATE)
                         || (state_q == LOAD_AFTER_FULL) || (state_q == LOAD_PARITY)
                         || (state_q == CHECK_PARITY_ERROR) || (state_q == WAIT_TILL_EMPTY);

endmodule
